exe_mdu: RTL
============

Name: exe_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit beside the execute stage's combinational ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers.
- Also services MFHI/MFLO/MTHI/MTLO.
- Raises a stall request to the pipeline control while busy, so dependent instructions hold in execute.

Parameters:
- XLEN, 32, operand/HI/LO width; must be even.
- BITS_PER_CYCLE, 1, product/quotient bits retired per iteration; legal values 1, 2, 4; must divide XLEN.
- ZERO_DIV_FAST, 1, 1 = divide-by-zero completes without iterating.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op/operands presented this cycle.
- in_ready  out  1  unit can accept an op.
- mdu_op  in  3  `MDU_NOP/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- src_a  in  XLEN  rs value (dividend / multiplicand / MTxx source).
- src_b  in  XLEN  rt value (divisor / multiplier).
- flush  in  1  abort the in-flight op (exception/branch squash).
- stall_req  out  1  hold the pipeline.
- done  out  1  one-cycle pulse: mul/div result committed.
- result  out  XLEN  MFHI/MFLO read data, combinational from HI/LO.
- hi  out  XLEN  architectural HI.
- lo  out  XLEN  architectural LO.

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi=0, lo=0, done=0, stall_req=0, in_ready=1, internal counters/accumulators cleared. A reset mid-op discards the op.
- Accept: on a rising edge with in_valid&in_ready. Ops other than mul/div (NOP/MFxx/MTxx) never leave IDLE.
- MTHI/MTLO: write hi/lo on the accept edge.
- MFHI/MFLO: result=hi/lo in the same cycle. If issued while state≠IDLE, stall_req=1 until done.
- States:
  - IDLE: in_ready=1. Mul/div accept → BUSY, with iteration counter N = XLEN/BITS_PER_CYCLE.
  - BUSY: in_ready=0, stall_req=1. Each cycle retires BITS_PER_CYCLE bits and decrements the counter. At 0 → DONE, with hi/lo written on that edge.
  - DONE: done=1 for exactly one cycle, in_ready=1, stall_req=0 → IDLE. A new op may be accepted in DONE (back-to-back).
- Latency: accept edge to done high is N+1 cycles (33 at defaults). Throughput is one op per N+1 cycles.
- Multiply: shift-add on operand magnitudes. Signed MULT negates the 2·XLEN product when sign(a)^sign(b). Result {hi,lo} = full 2·XLEN product.
- Divide: restoring shift-subtract on magnitudes.
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
- Divide by zero (src_b=0): lo = all ones, hi = src_a. With ZERO_DIV_FAST=1: IDLE→DONE directly (latency 1). Otherwise the full latency applies.
- Signed overflow (a = −2^(XLEN−1), b = −1): lo = −2^(XLEN−1), hi = 0, no trap.
- Flush:
  - During BUSY: → IDLE next edge, hi/lo unchanged, no done pulse.
  - In DONE: ignored (already committed).
  - In the accept cycle: the op is not accepted.
- in_valid while in_ready=0: ignored. The pipeline must hold operands under stall_req; the unit latches operands at accept and never re-samples them.
- Widths: internal accumulator 2·XLEN+1 bits. All arithmetic is unsigned on magnitudes; signs are applied only at commit.

Decomposition:
- Shared defines include (same file as the other op encodings): `MDU_* op codes (3 bits), `ZeroWord reuse, state encodings IDLE/BUSY/DONE.
- One sub-module, mdu_step: combinational, one iteration of BITS_PER_CYCLE shift-add or shift-subtract steps (mode input). The parent holds the FSM, counter and sign fix-up.

Test Plan:
- Reset then MULT a=7, b=0xFFFFFFFD → done at cycle +33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall_req high for cycles 1–32 after accept.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Repeat with BITS_PER_CYCLE=4 → same result, done at +9.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV 5/0 with ZERO_DIV_FAST=1 → done next cycle, lo=0xFFFFFFFF, hi=5.
- MTHI 0x1234, MULT 3×4, then flush at cycle 10 → no done, hi=0x1234, in_ready=1 next cycle. MFLO issued mid-op → stall_req until done, then result=lo.
- rst_n low at cycle 15 of a DIVU → all outputs zero immediately (async); IDLE after release. Back-to-back MULTs accepted in DONE → two done pulses 33 cycles apart.

Source files
------------

// File: rtl/exe_mdu_pkg.sv
// Shared op encodings, FSM states and op-decode helpers for the multiply/divide unit.
// Cycles with no MDU work are expressed by in_valid low.
package exe_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/exe_mdu_if.sv
// Execute-stage <-> multiply/divide unit bundle: issue handshake, operands, stall and HI/LO views.
interface exe_mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output in_valid, mdu_op, src_a, src_b, flush,
        input  in_ready, stall_req, done, result, hi, lo
    );

    modport slave (
        input  in_valid, mdu_op, src_a, src_b, flush,
        output in_ready, stall_req, done, result, hi, lo
    );
endinterface

// File: rtl/exe_mdu_step.sv
// One iteration of the iterative datapath: BITS_PER_CYCLE chained shift-add (multiply)
// or restoring shift-subtract (divide) steps on a 2*XLEN+1 bit accumulator.
module mdu_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*XLEN:0]  i_acc,
    input  logic [XLEN-1:0]  i_opnd,
    input  logic             i_div,
    output logic [2*XLEN:0]  o_acc
);
    logic [2*XLEN:0] w_chain [0:BITS_PER_CYCLE];

    assign w_chain[0] = i_acc;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_bit
            logic [2*XLEN:0] w_cur;
            logic [XLEN:0]   w_sum;
            logic [2*XLEN:0] w_shl;
            logic [XLEN+1:0] w_diff;

            assign w_cur = w_chain[gi];
            // Multiply: multiplier sits in the low half and is consumed LSB first.
            assign w_sum  = w_cur[2*XLEN:XLEN] + (w_cur[0] ? {1'b0, i_opnd} : '0);
            // Divide: partial remainder in the upper half, quotient bits shift in at bit 0.
            assign w_shl  = {w_cur[2*XLEN-1:0], 1'b0};
            assign w_diff = {1'b0, w_shl[2*XLEN:XLEN]} - {2'b00, i_opnd};

            assign w_chain[gi+1] = i_div
                ? (w_diff[XLEN+1] ? w_shl : {w_diff[XLEN:0], w_shl[XLEN-1:1], 1'b1})
                : {1'b0, w_sum, w_cur[XLEN-1:1]};
        end
    endgenerate

    assign o_acc = w_chain[BITS_PER_CYCLE];
endmodule

// File: rtl/exe_mdu.sv
// Iterative multiply/divide unit owning architectural HI/LO; stalls the pipeline while busy.
// Arithmetic runs on magnitudes; signs are applied when the result is committed.
module exe_mdu
    import exe_mdu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ZERO_DIV_FAST  = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    exe_mdu_if.slave mdu
);
    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int AW    = 2 * XLEN + 1;

    mdu_state_e      r_state;
    mdu_state_e      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_acc;
    logic [XLEN-1:0] r_opnd;
    logic [XLEN-1:0] r_a_raw;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_divz;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_muldiv;
    logic              w_div;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_b_zero;
    logic              w_zero_fast;
    logic              w_last;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [AW-1:0]     w_step_acc;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_muldiv    = op_is_muldiv(mdu.mdu_op);
    assign w_div       = op_is_div(mdu.mdu_op);
    assign w_signed    = op_is_signed(mdu.mdu_op);
    assign w_accept    = mdu.in_valid & w_in_ready & ~mdu.flush;
    assign w_a_neg     = w_signed & mdu.src_a[XLEN-1];
    assign w_b_neg     = w_signed & mdu.src_b[XLEN-1];
    assign w_mag_a     = w_a_neg ? -mdu.src_a : mdu.src_a;
    assign w_mag_b     = w_b_neg ? -mdu.src_b : mdu.src_b;
    assign w_b_zero    = (mdu.src_b == '0);
    assign w_zero_fast = (ZERO_DIV_FAST != 0) && w_div && w_b_zero;
    assign w_last      = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_next = ST_IDLE;
                if (w_accept && w_muldiv)
                    w_state_next = w_zero_fast ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                if (mdu.flush)   w_state_next = ST_IDLE;
                else if (w_last) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready    = 1'b1;
        mdu.stall_req = 1'b0;
        mdu.done      = 1'b0;
        case (r_state)
            ST_BUSY: begin
                w_in_ready    = 1'b0;
                mdu.stall_req = 1'b1;
            end
            ST_DONE: mdu.done = 1'b1;
            default: ;
        endcase
    end

    mdu_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_div),
        .o_acc  (w_step_acc)
    );

    // Operands are captured once at accept; the pipeline is free to change them afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_a_raw <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_divz  <= 1'b0;
        end else if (w_accept && w_muldiv) begin
            r_cnt   <= CW'(ITERS);
            r_div   <= w_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_divz  <= w_div & w_b_zero;
            r_a_raw <= mdu.src_a;
            r_opnd  <= w_div ? w_mag_b : w_mag_a;
            r_acc   <= {{(XLEN+1){1'b0}}, (w_div ? w_mag_a : w_mag_b)};
        end else if (r_state == ST_BUSY) begin
            if (mdu.flush) begin
                r_cnt <= '0;
            end else begin
                r_acc <= w_step_acc;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign w_prod = r_neg_q ? -w_step_acc[2*XLEN-1:0]   : w_step_acc[2*XLEN-1:0];
    assign w_quot = r_neg_q ? -w_step_acc[XLEN-1:0]     : w_step_acc[XLEN-1:0];
    assign w_rem  = r_neg_r ? -w_step_acc[2*XLEN-1:XLEN] : w_step_acc[2*XLEN-1:XLEN];

    // HI/LO change only on MTxx accept, fast divide-by-zero, or the final iteration edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept) begin
            if (w_zero_fast) begin
                r_hi <= mdu.src_a;
                r_lo <= '1;
            end else if (mdu.mdu_op == MDU_MTHI) begin
                r_hi <= mdu.src_a;
            end else if (mdu.mdu_op == MDU_MTLO) begin
                r_lo <= mdu.src_a;
            end
        end else if ((r_state == ST_BUSY) && !mdu.flush && w_last) begin
            if (!r_div) begin
                {r_hi, r_lo} <= w_prod;
            end else if (r_divz) begin
                r_hi <= r_a_raw;
                r_lo <= '1;
            end else begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end
        end
    end

    assign mdu.in_ready = w_in_ready;
    assign mdu.hi       = r_hi;
    assign mdu.lo       = r_lo;
    assign mdu.result   = (mdu.mdu_op == MDU_MFHI) ? r_hi : r_lo;
endmodule
